// File: rtl/comar_pkg.sv
// Shared definitions for the masked COMAR logic pipeline: op encodings,
// per-lane sizing constants and the input/output inversion decoders.
package comar_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_NAND = 2'd2,
    OP_NOR  = 2'd3
  } comar_op_e;

  localparam int RAND_PER_LANE = 6;
  localparam int SHARES        = 2;

  // OR and NOR are built from AND by De Morgan, so their inputs get inverted
  function automatic logic inv_in_dec(input logic [1:0] op);
    return (op == OP_OR) || (op == OP_NOR);
  endfunction

  // OR and NAND need the AND product inverted on the way out
  function automatic logic inv_out_dec(input logic [1:0] op);
    return (op == OP_OR) || (op == OP_NAND);
  endfunction

endpackage

// File: rtl/comar_lane.sv
// One first-order masked lane: refreshes both operands with fresh masks,
// registers the four share cross-products each re-masked, and only merges
// them in the final output XOR.
module comar_lane
  import comar_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en_i,
  input  logic                     inv_in_i,
  input  logic                     inv_out_i,
  input  logic [SHARES-1:0]        a_i,
  input  logic [SHARES-1:0]        b_i,
  input  logic [RAND_PER_LANE-1:0] r_i,
  output logic [SHARES-1:0]        c_o
);

  (* keep = "true" *) logic x0_q, x1_q, y0_q, y1_q;
  logic x0_d, x1_d, y0_d, y1_d;

  (* keep = "true" *) logic p00_q, p01_q, p10_q, p11_q, s_q;
  logic p00_d, p01_d, p10_d, p11_d, s_d;

  // Stage-1 refresh: each operand pair gets its own mask, inversion on share 0 only
  always_comb begin
    x0_d = a_i[0] ^ r_i[0] ^ inv_in_i;
    x1_d = a_i[1] ^ r_i[0];
    y0_d = b_i[0] ^ r_i[1] ^ inv_in_i;
    y1_d = b_i[1] ^ r_i[1];
  end

  // Stage-1 share registers form the boundary before any cross-product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0_q <= 1'b0;
      x1_q <= 1'b0;
      y0_q <= 1'b0;
      y1_q <= 1'b0;
    end else if (en_i) begin
      x0_q <= x0_d;
      x1_q <= x1_d;
      y0_q <= y0_d;
      y1_q <= y1_d;
    end
  end

  // Cross-products each masked with an independent bit; s carries the mask sum
  always_comb begin
    p00_d = (x0_q & y0_q) ^ r_i[2];
    p01_d = (x0_q & y1_q) ^ r_i[3];
    p10_d = (x1_q & y0_q) ^ r_i[4];
    p11_d = (x1_q & y1_q) ^ r_i[5];
    s_d   = r_i[2] ^ r_i[3] ^ r_i[4] ^ r_i[5];
  end

  // Stage-2 product registers keep every partial product separate until the output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p00_q <= 1'b0;
      p01_q <= 1'b0;
      p10_q <= 1'b0;
      p11_q <= 1'b0;
      s_q   <= 1'b0;
    end else if (en_i) begin
      p00_q <= p00_d;
      p01_q <= p01_d;
      p10_q <= p10_d;
      p11_q <= p11_d;
      s_q   <= s_d;
    end
  end

  assign c_o[0] = p00_q ^ p01_q ^ p10_q ^ p11_q ^ inv_out_i;
  assign c_o[1] = s_q;

endmodule

// File: rtl/comar_logic_pipe.sv
// WIDTH-lane masked AND/OR/NAND/NOR pipeline. Lanes hold the share data;
// this level carries the op and valid bits alongside and optionally adds a
// glitch-free output register.
module comar_logic_pipe
  import comar_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter bit OUT_REG = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       in_valid,
  input  logic [1:0]                 op,
  input  logic [2*WIDTH-1:0]         a,
  input  logic [2*WIDTH-1:0]         b,
  input  logic [6*WIDTH-1:0]         r,
  output logic                       out_valid,
  output logic [2*WIDTH-1:0]         c
);

  logic [1:0]         op1_q, op2_q;
  logic               vld1_q, vld2_q;
  logic               inv_in, inv_out;
  logic [2*WIDTH-1:0] lane_c;

  assign inv_in  = inv_in_dec(op);
  assign inv_out = inv_out_dec(op2_q);

  // Op and valid travel with the data so an op change never touches an in-flight result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op1_q  <= 2'd0;
      op2_q  <= 2'd0;
      vld1_q <= 1'b0;
      vld2_q <= 1'b0;
    end else if (en) begin
      op1_q  <= op;
      op2_q  <= op1_q;
      vld1_q <= in_valid;
      vld2_q <= vld1_q;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    comar_lane u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_i      (en),
      .inv_in_i  (inv_in),
      .inv_out_i (inv_out),
      .a_i       (a[SHARES*i +: SHARES]),
      .b_i       (b[SHARES*i +: SHARES]),
      .r_i       (r[RAND_PER_LANE*i +: RAND_PER_LANE]),
      .c_o       (lane_c[SHARES*i +: SHARES])
    );
  end

  if (OUT_REG) begin : g_out_reg
    (* keep = "true" *) logic [2*WIDTH-1:0] c_q;
    logic                                    vld3_q;

    // Output stage hides the combinational merge glitches from downstream logic
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        c_q    <= '0;
        vld3_q <= 1'b0;
      end else if (en) begin
        c_q    <= lane_c;
        vld3_q <= vld2_q;
      end
    end

    assign c         = c_q;
    assign out_valid = vld3_q;
  end else begin : g_out_comb
    assign c         = lane_c;
    assign out_valid = vld2_q;
  end

endmodule

// File: tb/tb_comar_logic_pipe.sv
// Directed bench for comar_logic_pipe: one instance per output mode share the
// same stimulus; a small unmasked scoreboard tracks what each should show.
module tb_comar_logic_pipe;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en;
  logic           inVld;
  logic [1:0]     opSel;
  logic [2*W-1:0] aBus, bBus;
  logic [6*W-1:0] rBus;
  logic           outValid0, outValid1;
  logic [2*W-1:0] cBus0, cBus1;

  int vectorCount = 0;
  int missCount   = 0;

  logic           mv1, mv2, mv3;
  logic [W-1:0]   mf1, mf2, mf3;
  logic [W-1:0]   ms2, ms3;

  comar_logic_pipe #(.WIDTH(W), .OUT_REG(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(inVld), .op(opSel),
    .a(aBus), .b(bBus), .r(rBus), .out_valid(outValid0), .c(cBus0)
  );

  comar_logic_pipe #(.WIDTH(W), .OUT_REG(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(inVld), .op(opSel),
    .a(aBus), .b(bBus), .r(rBus), .out_valid(outValid1), .c(cBus1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [W-1:0] unmaskBus(input logic [2*W-1:0] bus);
    logic [W-1:0] res;
    for (int i = 0; i < W; i++) res[i] = bus[2*i] ^ bus[2*i+1];
    return res;
  endfunction

  function automatic logic [W-1:0] share1Bus(input logic [2*W-1:0] bus);
    logic [W-1:0] res;
    for (int i = 0; i < W; i++) res[i] = bus[2*i+1];
    return res;
  endfunction

  function automatic logic [W-1:0] randSum(input logic [6*W-1:0] rv);
    logic [W-1:0] res;
    for (int i = 0; i < W; i++) res[i] = rv[6*i+2] ^ rv[6*i+3] ^ rv[6*i+4] ^ rv[6*i+5];
    return res;
  endfunction

  function automatic logic [W-1:0] opResult(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    case (o)
      2'd0:    return x & y;
      2'd1:    return x | y;
      2'd2:    return ~(x & y);
      default: return ~(x | y);
    endcase
  endfunction

  task automatic clearModel();
    mv1 = 1'b0; mv2 = 1'b0; mv3 = 1'b0;
    mf1 = '0;   mf2 = '0;   mf3 = '0;
    ms2 = '0;   ms3 = '0;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_vld0"}, {31'd0, outValid0}, 32'd0);
    checkOutput({tag, "_vld1"}, {31'd0, outValid1}, 32'd0);
    checkOutput({tag, "_c0"}, {16'd0, cBus0}, 32'd0);
    checkOutput({tag, "_c1"}, {16'd0, cBus1}, 32'd0);
  endtask

  task automatic checkModel();
    checkOutput("vld_comb", {31'd0, outValid0}, {31'd0, mv2});
    checkOutput("vld_reg", {31'd0, outValid1}, {31'd0, mv3});
    if (mv2) begin
      checkOutput("res_comb", {24'd0, unmaskBus(cBus0)}, {24'd0, mf2});
      checkOutput("s_comb", {24'd0, share1Bus(cBus0)}, {24'd0, ms2});
    end
    if (mv3) begin
      checkOutput("res_reg", {24'd0, unmaskBus(cBus1)}, {24'd0, mf3});
      checkOutput("s_reg", {24'd0, share1Bus(cBus1)}, {24'd0, ms3});
    end
  endtask

  task automatic applyStimulus(input logic enV, input logic vldV, input logic [1:0] opV,
                               input logic [W-1:0] aVal, input logic [W-1:0] bVal,
                               input logic [W-1:0] aMask, input logic [W-1:0] bMask);
    logic [63:0] rTmp;
    for (int i = 0; i < W; i++) begin
      aBus[2*i]   = aVal[i] ^ aMask[i];
      aBus[2*i+1] = aMask[i];
      bBus[2*i]   = bVal[i] ^ bMask[i];
      bBus[2*i+1] = bMask[i];
    end
    rTmp  = {$urandom(), $urandom()};
    rBus  = rTmp[6*W-1:0];
    en    = enV;
    inVld = vldV;
    opSel = opV;
    @(posedge clk);
    if (en) begin
      mv3 = mv2; mf3 = mf2; ms3 = ms2;
      mv2 = mv1; mf2 = mf1; ms2 = randSum(rBus);
      mv1 = inVld; mf1 = opResult(opSel, aVal, bVal);
    end
    #1;
    checkModel();
  endtask

  task automatic randomStep(input logic enV, input logic vldV);
    logic [31:0] rv;
    rv = $urandom();
    applyStimulus(enV, vldV, rv[1:0], rv[9:2], rv[17:10], rv[25:18], W'($urandom()));
  endtask

  logic [W-1:0] expB2B [4];

  initial begin
    expB2B[0] = 8'h30; expB2B[1] = 8'hFC; expB2B[2] = 8'hCF; expB2B[3] = 8'h03;
    rst_n = 1'b0; en = 1'b0; inVld = 1'b0; opSel = 2'd0;
    aBus = '0; bBus = '0; rBus = '0;
    clearModel();
    #12;
    checkReset("por");
    rst_n = 1'b1;
    #1;

    // Reset state: idle cycles after release never produce a result
    for (int k = 0; k < 3; k++) randomStep(1'b1, 1'b0);

    // Single AND then OR on F0/3C
    applyStimulus(1'b1, 1'b1, 2'd0, 8'hF0, 8'h3C, W'($urandom()), W'($urandom()));
    applyStimulus(1'b1, 1'b0, 2'd3, 8'h00, 8'h00, W'($urandom()), W'($urandom()));
    checkOutput("and_F0_3C", {24'd0, unmaskBus(cBus0)}, 32'h30);
    applyStimulus(1'b1, 1'b1, 2'd1, 8'hF0, 8'h3C, W'($urandom()), W'($urandom()));
    applyStimulus(1'b1, 1'b0, 2'd2, 8'h00, 8'h00, W'($urandom()), W'($urandom()));
    checkOutput("or_F0_3C", {24'd0, unmaskBus(cBus0)}, 32'hFC);
    for (int k = 0; k < 2; k++) randomStep(1'b1, 1'b0);

    // Back-to-back op changes on the same operands
    for (int k = 0; k < 6; k++) begin
      if (k < 4) applyStimulus(1'b1, 1'b1, 2'(k), 8'hF0, 8'h3C, W'($urandom()), W'($urandom()));
      else       randomStep(1'b1, 1'b0);
      if (k >= 1 && k <= 4) checkOutput("b2b_comb", {24'd0, unmaskBus(cBus0)}, {24'd0, expB2B[k-1]});
      if (k >= 2)           checkOutput("b2b_reg", {24'd0, unmaskBus(cBus1)}, {24'd0, expB2B[k-2]});
    end

    // Stall three cycles with the transaction in stage 1; inputs wiggle meanwhile
    applyStimulus(1'b1, 1'b1, 2'd0, 8'hA5, 8'hFF, W'($urandom()), W'($urandom()));
    for (int k = 0; k < 3; k++) randomStep(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 2'd1, 8'h00, 8'h00, W'($urandom()), W'($urandom()));
    checkOutput("stall_comb", {24'd0, unmaskBus(cBus0)}, 32'hA5);
    for (int k = 0; k < 2; k++) randomStep(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'd3, 8'h00, 8'h00, W'($urandom()), W'($urandom()));
    checkOutput("stall_reg", {24'd0, unmaskBus(cBus1)}, 32'hA5);

    // Fixed operands, fresh randomness every cycle
    for (int k = 0; k < 8; k++)
      applyStimulus(1'b1, 1'b1, 2'd2, 8'h5A, 8'h33, W'($urandom()), W'($urandom()));

    // Every share combination in every lane under every op
    for (int o = 0; o < 4; o++) begin
      for (int k = 0; k < 16; k++) begin
        logic [3:0] sh;
        sh = 4'(k);
        applyStimulus(1'b1, 1'b1, 2'(o), {W{sh[0] ^ sh[1]}}, {W{sh[2] ^ sh[3]}}, {W{sh[1]}}, {W{sh[3]}});
      end
    end

    // Random traffic with random stalls and bubbles
    for (int k = 0; k < 200; k++) begin
      logic [31:0] sel;
      sel = $urandom();
      randomStep(sel[2:0] != 3'd0, sel[3] | sel[4]);
    end

    // Asynchronous reset in the middle of traffic
    for (int k = 0; k < 4; k++) randomStep(1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkReset("async_rst");
    clearModel();
    @(posedge clk);
    #2;
    checkReset("rst_hold");
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) randomStep(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'd3, 8'hF0, 8'h3C, W'($urandom()), W'($urandom()));
    applyStimulus(1'b1, 1'b0, 2'd0, 8'h00, 8'h00, W'($urandom()), W'($urandom()));
    checkOutput("post_rst_nor", {24'd0, unmaskBus(cBus0)}, 32'h03);
    for (int k = 0; k < 3; k++) randomStep(1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/comar_logic_pipe.md
Name: comar_logic_pipe

Overview:
- Parametrised successor to the single-bit 2-share COMAR gadgets: WIDTH independent first-order lanes, each computing AND/OR/NAND/NOR of two Boolean-masked inputs with reused-fresh-mask refreshing.
- Adds a per-transaction op select, valid tracking, pipeline stall, async reset and an optional output register.
- Drop-in element for masked S-box datapaths that need byte- or word-wide nonlinear layers.

Parameters:
- WIDTH, 8, number of independent lanes (unmasked bit width).
- OUT_REG, 0, 0: combinational output XOR, latency 2. 1: extra output register stage, latency 3, glitch-free outputs.

Ports:
- clk  input  1  clock; all registers rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  pipeline advance; 0 freezes every register (data, op, valid).
- in_valid  input  1  a/b/op are a valid transaction this cycle.
- op  input  2  operation: 0 AND, 1 OR, 2 NAND, 3 NOR.
- a  input  2*WIDTH  shares of operand A; lane i is a[2i+1:2i], share0 at bit 2i.
- b  input  2*WIDTH  shares of operand B; same layout.
- r  input  6*WIDTH  fresh randomness; lane i uses r[6i+5:6i]; bus is sampled every enabled cycle.
- out_valid  output  1  c holds a valid result.
- c  output  2*WIDTH  result shares; same layout.

Behaviour:
- Reset (rst_n=0, asynchronous): all data, op and valid registers clear to 0. out_valid=0, c=0.
- The cleared op register decodes as AND, so c=0 immediately after reset.
- Stage 1, registered on an enabled edge:
  - inv_in = (op==OR or op==NOR).
  - Per lane: x0 = a0^r0^inv_in, x1 = a1^r0, y0 = b0^r1^inv_in, y1 = b1^r1.
  - op and in_valid are captured alongside.
- Stage 2, registered on an enabled edge:
  - p00 = x0&y0 ^ r2, p01 = x0&y1 ^ r3, p10 = x1&y0 ^ r4, p11 = x1&y1 ^ r5.
  - s = r2^r3^r4^r5.
  - r here is the bus value in the stage-2 cycle, not the stage-1 cycle.
  - op and valid advance with the data.
- Output, per lane:
  - c0 = p00^p01^p10^p11^inv_out, where inv_out = (op2==OR or op2==NAND).
  - c1 = s.
  - OUT_REG=1: c0, c1, op-derived inversion and valid pass through one more enabled register.
- Correctness: c0^c1 = f(a0^a1, b0^b1) for the selected op in every lane, for any r.
- Only the stage-2 op register (op2) drives output inversion. An op change on the next transaction must not affect an in-flight result.
- Latency: 2 enabled cycles (OUT_REG=0) or 3 (OUT_REG=1) from in_valid to out_valid. Stalled cycles do not count.
- Throughput: one transaction per enabled cycle, back-to-back, no bubbles required.
- in_valid=0 with en=1:
  - Data registers still load from the current inputs.
  - The valid bit propagates 0.
  - c is don't-care while out_valid=0.
- en=0: every register holds. r is ignored that cycle. out_valid and c are stable.
- Reset mid-operation: in-flight transactions are discarded, with no output pulse. First valid result appears latency cycles after the first post-reset in_valid.
- No share recombination before a register boundary. XOR of stage-1 shares with each other is forbidden; only the final c0 XOR merges products. Synthesis must keep registers; keep attributes are required.

Decomposition:
- Package comar_pkg:
  - op encodings: OP_AND=0, OP_OR=1, OP_NAND=2, OP_NOR=3.
  - RAND_PER_LANE=6, SHARES=2.
  - inv_in/inv_out decode functions.
- Sub-module comar_lane: one lane, with the stage-1/stage-2 data registers and combinational c0/c1.
- The top instantiates WIDTH lanes and holds the shared op/valid pipeline and optional output stage.

Test Plan:
- Reset: assert rst_n=0 mid-stream with random traffic -> out_valid=0 and c=0 asynchronously. After release with no in_valid, out_valid stays 0.
- AND/OR, WIDTH=8, OUT_REG=0, random share splits and random r: unmasked a=0xF0, b=0x3C. op=AND -> out_valid 2 cycles later, unmasked c=0x30. op=OR -> 0xFC.
- Back-to-back op changes: AND, OR, NAND, NOR on consecutive cycles with a=0xF0, b=0x3C -> four consecutive out_valid cycles with c=0x30, 0xFC, 0xCF, 0x03.
- Stall: issue a=0xA5, b=0xFF, AND, then en=0 for 3 cycles mid-pipe -> c unchanged during stall, result 0xA5 after 2 enabled cycles. Same with OUT_REG=1 -> 3 enabled cycles.
- Randomness dependence: fix a, b, op and vary only r across runs -> unmasked c constant; c1 lane i always equals r2^r3^r4^r5 of the stage-2 cycle; c0 toggles with r.
- Exhaustive per lane: all 16 share combinations × 4 ops × random r, WIDTH=1 and WIDTH=8 -> scoreboard match on every out_valid, no extra or missing out_valid pulses.
